// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // rs1 is treated as signed by everything except the fully unsigned ops
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiply / restoring divide datapath with final sign fix.
// One 2*DATA_W accumulator serves as product (mul) or {remainder, quotient} (div).
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              fix,
  input  logic              spec_load,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] spec_val,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   opnd_reg;
  logic [2:0]          op_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic [DATA_W-1:0]   result_reg;

  logic                neg_a, neg_b;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_trial;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic [DATA_W-1:0]   fix_val;

  assign neg_a = op_signed_a(funct3) & src_a[DATA_W-1];
  assign neg_b = op_signed_b(funct3) & src_b[DATA_W-1];
  assign mag_a = neg_a ? -src_a : src_a;
  assign mag_b = neg_b ? -src_b : src_b;

  // Multiplier sits in the low half and is consumed one bit per shift
  assign mul_sum  = {1'b0, acc_reg[2*DATA_W-1:DATA_W]} + {1'b0, opnd_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[DATA_W-1:1]}
                               : {1'b0, acc_reg[2*DATA_W-1:1]};

  // Trial subtract on {remainder, next dividend bit}; carry-out bit set means negative
  assign div_trial = acc_reg[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_reg};
  assign div_next  = div_trial[DATA_W] ? {acc_reg[2*DATA_W-2:0], 1'b0}
                                       : {div_trial[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b1};

  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
  assign rem_fix  = sign_a_reg ? -acc_reg[2*DATA_W-1:DATA_W] : acc_reg[2*DATA_W-1:DATA_W];

  always_comb begin
    fix_val = prod_fix[DATA_W-1:0];
    case (op_reg)
      F3_MUL:                      fix_val = prod_fix[DATA_W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*DATA_W-1:DATA_W];
      F3_DIV, F3_DIVU:             fix_val = quo_fix;
      default:                     fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      opnd_reg   <= '0;
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      if (load) begin
        op_reg     <= funct3;
        sign_a_reg <= neg_a;
        sign_b_reg <= neg_b;
        acc_reg    <= funct3[2] ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
        opnd_reg   <= funct3[2] ? mag_b : mag_a;
      end else if (step) begin
        acc_reg <= op_reg[2] ? div_next : mul_next;
      end
      if (fix) begin
        result_reg <= fix_val;
      end else if (spec_load) begin
        result_reg <= spec_val;
      end
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: control FSM, iteration counter,
// divide special-case shortcut and pipeline stall request.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              stall_req
);

  localparam int               CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]    LAST = CW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_e          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            load, step, fix, spec_load;
  logic            div_zero, div_ovf, special;
  logic [DATA_W-1:0] spec_val;

  assign div_zero = funct3[2] && (src_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
  assign special  = div_zero || div_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    spec_val = '1;
    if (div_zero)
      spec_val = funct3[1] ? src_a : '1;
    else if (div_ovf)
      spec_val = funct3[1] ? '0 : MIN_NEG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    spec_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          cnt_next = '0;
          if (special) begin
            spec_load  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        step     = 1'b1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST)
          state_next = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    // A flushed instruction must leave no trace: no accept, no result update
    if (flush) begin
      state_next = IDLE;
      load       = 1'b0;
      step       = 1'b0;
      fix        = 1'b0;
      spec_load  = 1'b0;
    end
  end

  muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .spec_load (spec_load),
    .funct3    (funct3),
    .src_a     (src_a),
    .src_b     (src_b),
    .spec_val  (spec_val),
    .result    (result)
  );

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign stall_req = (start && (state_reg == IDLE) && !flush)
                   || (state_reg == CALC) || (state_reg == FIX);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, alongside the main ALU. It accepts one M-extension operation at a time and sequences a radix-2 shift-add multiply or restoring divide over DATA_W cycles. It raises a stall request so the hazard unit holds IF/ID/EX until the result is ready. Output is muxed into the EX result path when done is high.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  EX holds a valid M-extension instruction (Funct7 = 0000001, R-type)
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  DATA_W  rs1 operand
src_b  input  DATA_W  rs2 operand
flush  input  1  branch/jump flush of EX; aborts the current operation
busy  output  1  operation in progress (state != IDLE)
done  output  1  result valid, one-cycle pulse
result  output  DATA_W  registered result
stall_req  output  1  hold pipeline: (start & state==IDLE & ~flush) | state==CALC | state==FIX

Behaviour:
- Reset (sync, active-high): state IDLE; busy=0, done=0, result=0, all internal registers 0. Reset overrides start and flush on the same edge.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0 at edge k:
  - latch op, operand signs and operand magnitudes; iteration counter = 0.
  - Special divide cases go IDLE->DONE directly with result loaded.
  - Otherwise go IDLE->CALC.
- Signedness:
  - Signed operands: MUL, MULH, DIV, REM (both operands); MULHSU (src_a only).
  - Unsigned: MULHU, DIVU, REMU.
  - Magnitude is two's-complement negate when the operand is signed and negative. MUL uses the signed path; its low word is sign-agnostic.
- CALC: one iteration per cycle; counter increments; at count DATA_W-1 go to FIX. CALC occupies edges k+1..k+DATA_W.
  - Multiply: 2*DATA_W product register; add multiplicand when multiplier LSB=1, then shift right.
  - Divide: restoring; shift remainder/quotient left, trial subtract divisor, keep the result if non-negative and set the quotient bit.
- FIX (edge k+DATA_W+1): negate the product if signs differ. Negate the quotient if signs differ (signed div). Negate the remainder if the dividend is negative (signed rem). Select the low/high word per op, register it into result, go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE. For iterative ops, done is high in the cycle after edge k+DATA_W+1, i.e. 34 cycles after the start edge at DATA_W=32.
- Special cases (1-cycle latency, done high in the cycle after edge k):
  - divisor 0: DIV/DIVU give all ones; REM/REMU give src_a.
  - DIV with src_a = 100..0 and src_b = all ones: quotient 100..0; REM gives 0.
- start is ignored outside IDLE; a new op is accepted only once back in IDLE.
- flush: from any state, the next edge goes to IDLE; done is not asserted; result holds its previous value. flush and start in the same IDLE cycle: flush wins, op not accepted.
- result holds its value until the next FIX or special-case load.
- All arithmetic is DATA_W or 2*DATA_W wide, unsigned after magnitude conversion; no overflow flags.

Decomposition:
- Package muldiv_pkg: funct3 constants (F3_MUL … F3_REMU), state enum (IDLE, CALC, FIX, DONE), M-extension Funct7 constant 7'b0000001.
- Sub-module muldiv_datapath: product/remainder/quotient registers, the iteration step and the sign fix, controlled by FSM strobes (load, step, fix).
- Top muldiv_unit contains the FSM, counter, special-case detection and the stall_req/done/busy logic.

Test Plan:
- Reset mid-CALC: assert reset at cycle 10 after start -> next cycle state IDLE, busy=0, done=0, result=0.
- MUL src_a=7, src_b=0xFFFFFFFD -> done high exactly 34 cycles after the start edge, result=0xFFFFFFEB; stall_req high from the start cycle through FIX, low in DONE.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0. All special cases have done high in the cycle after the start edge.
- flush at CALC iteration 5 -> IDLE next cycle, no done pulse, result unchanged. start asserted while busy -> ignored. start+flush in IDLE -> no op accepted.
